// File: rtl/acondicionador_entradas_pkg.sv
// Shared encodings and default timing for the board input conditioner.
package acondicionador_entradas_pkg;

   // Default timing at 100 MHz: 10 ms debounce, 0.5 s first repeat, 0.2 s repeat period
   localparam int unsigned DB_CYCLES_DEF     = 1_000_000;
   localparam int unsigned REPEAT_DELAY_DEF  = 50_000_000;
   localparam int unsigned REPEAT_PERIOD_DEF = 20_000_000;
   localparam int unsigned CNT_W_DEF         = 26;

   // Channel map of the conditioned input vector
   localparam int unsigned N_CH         = 8;
   localparam int unsigned N_UD         = 2;
   localparam int unsigned CH_ARRIBA    = 0;
   localparam int unsigned CH_ABAJO     = 1;
   localparam int unsigned CH_IZQ       = 2;
   localparam int unsigned CH_DER       = 3;
   localparam int unsigned CH_ESCRIBE   = 4;
   localparam int unsigned CH_CRONO     = 5;
   localparam int unsigned CH_CR_ACTIVO = 6;
   localparam int unsigned CH_RESET     = 7;

   typedef enum logic [1:0] {
      LIBRE       = 2'd0,
      M_ESCRIBE   = 2'd1,
      M_CRONO     = 2'd2,
      M_CR_ACTIVO = 2'd3
   } modo_e;

   // Debounced mode switches, msb-first in channel order
   typedef struct packed {
      logic reset;
      logic cr_activo;
      logic crono;
      logic escribe;
   } modo_sw_t;

   // Mode transition: enter only from LIBRE with exactly one mode switch and no reinit,
   // leave as soon as the own switch drops.
   function automatic modo_e modo_siguiente(input modo_e st, input modo_sw_t sw);
      modo_e nx;
      nx = LIBRE;
      case (st)
         LIBRE: begin
            if (!sw.reset) begin
               case ({sw.cr_activo, sw.crono, sw.escribe})
                  3'b001:  nx = M_ESCRIBE;
                  3'b010:  nx = M_CRONO;
                  3'b100:  nx = M_CR_ACTIVO;
                  default: nx = LIBRE;
               endcase
            end
         end
         M_ESCRIBE:   nx = sw.escribe   ? M_ESCRIBE   : LIBRE;
         M_CRONO:     nx = sw.crono     ? M_CRONO     : LIBRE;
         M_CR_ACTIVO: nx = sw.cr_activo ? M_CR_ACTIVO : LIBRE;
         default:     nx = LIBRE;
      endcase
      return nx;
   endfunction

endpackage

// File: rtl/acondicionador_entradas_debounce_canal.sv
// One input channel: 2-FF synchroniser, debounce counter, stable level and rise flag.
module debounce_canal
   import acondicionador_entradas_pkg::*;
#(
   parameter int unsigned DB_CYCLES = DB_CYCLES_DEF,
   parameter int unsigned CNT_W     = CNT_W_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pin_i,
   output logic stable_o,
   output logic rise_o
);

   logic             sync1_q, sync2_q;
   logic             stable_q, stable_d;
   logic             rise_q, rise_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Accept the synchronised value only after DB_CYCLES consecutive differing cycles
   always_comb begin
      stable_d = stable_q;
      rise_d   = 1'b0;
      cnt_d    = '0;
      if (sync2_q != stable_q) begin
         if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
            stable_d = sync2_q;
            rise_d   = sync2_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // Synchroniser and debounce state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         rise_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= pin_i;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         rise_q   <= rise_d;
         cnt_q    <= cnt_d;
      end
   end

   assign stable_o = stable_q;
   assign rise_o   = rise_q;

endmodule

// File: rtl/acondicionador_entradas.sv
// Board input conditioner: debounced button pulses with up/down auto-repeat and exclusive mode levels.
module acondicionador_entradas
   import acondicionador_entradas_pkg::*;
#(
   parameter int unsigned DB_CYCLES     = DB_CYCLES_DEF,
   parameter int unsigned REPEAT_DELAY  = REPEAT_DELAY_DEF,
   parameter int unsigned REPEAT_PERIOD = REPEAT_PERIOD_DEF,
   parameter int unsigned CNT_W         = CNT_W_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_arriba,
   input  logic btn_abajo,
   input  logic btn_izquierda,
   input  logic btn_derecha,
   input  logic sw_escribe,
   input  logic sw_crono,
   input  logic sw_cr_activo,
   input  logic sw_reset,
   output logic push_arriba,
   output logic push_abajo,
   output logic push_izquierda,
   output logic push_derecha,
   output logic escribe1,
   output logic crono1,
   output logic cr_activo1,
   output logic reset1
);

   logic [N_CH-1:0] pin_raw;
   logic [N_CH-1:0] stable;
   logic [N_CH-1:0] rise;

   assign pin_raw = {sw_reset, sw_cr_activo, sw_crono, sw_escribe,
                     btn_derecha, btn_izquierda, btn_abajo, btn_arriba};

   for (genvar g = 0; g < N_CH; g++) begin : g_canal
      debounce_canal #(
         .DB_CYCLES (DB_CYCLES),
         .CNT_W     (CNT_W)
      ) u_db (
         .clk      (clk),
         .rst_n    (reset),
         .pin_i    (pin_raw[g]),
         .stable_o (stable[g]),
         .rise_o   (rise[g])
      );
   end

   // Rise flags of the switches and levels of left/right are not needed downstream
   logic unused_canal;
   assign unused_canal = ^{rise[CH_RESET:CH_ESCRIBE], stable[CH_DER:CH_IZQ]};

   // ---------------- auto-repeat for up/down ----------------
   logic [N_UD-1:0][CNT_W-1:0] rep_cnt_q, rep_cnt_d;
   logic [N_UD-1:0]            rep_act_q, rep_act_d;
   logic [N_UD-1:0]            rep_first_q, rep_first_d;
   logic [N_UD-1:0]            ud_pulse_d;
   logic                       both_ud;

   // Press pulse, then first repeat after REPEAT_DELAY and every REPEAT_PERIOD while held alone
   always_comb begin
      both_ud     = stable[CH_ARRIBA] & stable[CH_ABAJO];
      rep_cnt_d   = rep_cnt_q;
      rep_act_d   = rep_act_q;
      rep_first_d = rep_first_q;
      ud_pulse_d  = '0;
      for (int i = 0; i < N_UD; i++) begin
         if (both_ud || !stable[i]) begin
            rep_cnt_d[i]   = '0;
            rep_act_d[i]   = 1'b0;
            rep_first_d[i] = 1'b1;
         end else if (rise[i]) begin
            rep_cnt_d[i]   = '0;
            rep_act_d[i]   = 1'b1;
            rep_first_d[i] = 1'b1;
            ud_pulse_d[i]  = 1'b1;
         end else if (rep_act_q[i]) begin
            if (rep_first_q[i] && rep_cnt_q[i] == CNT_W'(REPEAT_DELAY - 1)) begin
               rep_cnt_d[i]   = '0;
               rep_first_d[i] = 1'b0;
               ud_pulse_d[i]  = 1'b1;
            end else if (!rep_first_q[i] && rep_cnt_q[i] == CNT_W'(REPEAT_PERIOD - 1)) begin
               rep_cnt_d[i]  = '0;
               ud_pulse_d[i] = 1'b1;
            end else begin
               rep_cnt_d[i] = rep_cnt_q[i] + CNT_W'(1);
            end
         end else begin
            rep_cnt_d[i] = '0;
         end
      end
   end

   // ---------------- mode FSM ----------------
   modo_e    state_q, state_d;
   modo_sw_t sw_st;

   assign sw_st = modo_sw_t'(stable[CH_RESET:CH_ESCRIBE]);

   // Next mode from the debounced switches
   always_comb begin
      state_d = modo_siguiente(state_q, sw_st);
   end

   logic [3:0] push_q;
   logic       escribe1_q, crono1_q, cr_activo1_q, reset1_q;

   // State and all outputs registered together; reset1 only across a LIBRE->LIBRE step
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= LIBRE;
         rep_cnt_q    <= '0;
         rep_act_q    <= '0;
         rep_first_q  <= '1;
         push_q       <= '0;
         escribe1_q   <= 1'b0;
         crono1_q     <= 1'b0;
         cr_activo1_q <= 1'b0;
         reset1_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         rep_cnt_q    <= rep_cnt_d;
         rep_act_q    <= rep_act_d;
         rep_first_q  <= rep_first_d;
         push_q       <= {rise[CH_DER], rise[CH_IZQ], ud_pulse_d};
         escribe1_q   <= (state_d == M_ESCRIBE);
         crono1_q     <= (state_d == M_CRONO);
         cr_activo1_q <= (state_d == M_CR_ACTIVO);
         reset1_q     <= sw_st.reset && (state_q == LIBRE) && (state_d == LIBRE);
      end
   end

   assign push_arriba    = push_q[0];
   assign push_abajo     = push_q[1];
   assign push_izquierda = push_q[2];
   assign push_derecha   = push_q[3];
   assign escribe1       = escribe1_q;
   assign crono1         = crono1_q;
   assign cr_activo1     = cr_activo1_q;
   assign reset1         = reset1_q;

endmodule

// File: tb/tb_acondicionador_entradas.sv
// Scoreboard bench for acondicionador_entradas with short debounce/repeat timing.
module tb_acondicionador_entradas;

   localparam int unsigned DB = 4;
   localparam int unsigned RD = 20;
   localparam int unsigned RP = 8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] pins;
   logic       push_arriba, push_abajo, push_izquierda, push_derecha;
   logic       escribe1, crono1, cr_activo1, reset1;
   logic [7:0] outs;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [7:0] sb_q[$];
   int         arr_log[$];
   int         abj_log[$];
   int         izq_log[$];
   int         der_log[$];

   acondicionador_entradas #(
      .DB_CYCLES     (DB),
      .REPEAT_DELAY  (RD),
      .REPEAT_PERIOD (RP),
      .CNT_W         (8)
   ) dut (
      .clk            (clk),
      .reset          (rst_n),
      .btn_arriba     (pins[0]),
      .btn_abajo      (pins[1]),
      .btn_izquierda  (pins[2]),
      .btn_derecha    (pins[3]),
      .sw_escribe     (pins[4]),
      .sw_crono       (pins[5]),
      .sw_cr_activo   (pins[6]),
      .sw_reset       (pins[7]),
      .push_arriba    (push_arriba),
      .push_abajo     (push_abajo),
      .push_izquierda (push_izquierda),
      .push_derecha   (push_derecha),
      .escribe1       (escribe1),
      .crono1         (crono1),
      .cr_activo1     (cr_activo1),
      .reset1         (reset1)
   );

   assign outs = {reset1, cr_activo1, crono1, escribe1,
                  push_derecha, push_izquierda, push_abajo, push_arriba};

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: debounced levels, press/repeat timing by elapsed time, mode rules
   bit [7:0]    m_s1, m_s2, m_st, m_pst;
   int unsigned m_cnt [8];
   bit [1:0]    m_armed;
   int          m_press [2];
   int          m_edge = 0;
   int          m_mode = 0;

   always @(posedge clk) begin : model
      logic [7:0] exp;
      int         nm;
      int         el;
      int         nsel;
      bit         both;
      m_edge = m_edge + 1;
      exp    = '0;
      if (!rst_n) begin
         m_s1 = '0; m_s2 = '0; m_st = '0; m_pst = '0;
         m_armed = '0; m_mode = 0;
         for (int i = 0; i < 8; i++) m_cnt[i] = 0;
      end else begin
         both = m_st[0] && m_st[1];
         for (int ch = 0; ch < 2; ch++) begin
            if (!m_st[ch] || both) begin
               m_armed[ch] = 1'b0;
            end else if (!m_pst[ch]) begin
               m_armed[ch] = 1'b1;
               m_press[ch] = m_edge;
               exp[ch]     = 1'b1;
            end else if (m_armed[ch]) begin
               el = m_edge - m_press[ch];
               if (el >= int'(RD) && ((el - int'(RD)) % int'(RP)) == 0) exp[ch] = 1'b1;
            end
         end
         exp[2] = m_st[2] && !m_pst[2];
         exp[3] = m_st[3] && !m_pst[3];
         nsel = int'(m_st[4]) + int'(m_st[5]) + int'(m_st[6]);
         case (m_mode)
            0:       nm = (!m_st[7] && nsel == 1) ? (m_st[4] ? 1 : (m_st[5] ? 2 : 3)) : 0;
            1:       nm = m_st[4] ? 1 : 0;
            2:       nm = m_st[5] ? 2 : 0;
            default: nm = m_st[6] ? 3 : 0;
         endcase
         exp[4] = (nm == 1);
         exp[5] = (nm == 2);
         exp[6] = (nm == 3);
         exp[7] = m_st[7] && m_mode == 0 && nm == 0;
         m_mode = nm;
         m_pst  = m_st;
         for (int i = 0; i < 8; i++) begin
            if (m_s2[i] != m_st[i]) begin
               if (m_cnt[i] == DB - 1) begin
                  m_st[i]  = m_s2[i];
                  m_cnt[i] = 0;
               end else begin
                  m_cnt[i] = m_cnt[i] + 1;
               end
            end else begin
               m_cnt[i] = 0;
            end
         end
         m_s2 = m_s1;
         m_s1 = pins;
      end
      sb_q.push_back(exp);
   end

   // Monitor: compare every cycle's outputs against the model, log pulse times
   always @(negedge clk) begin : monitor
      logic [7:0] exp;
      if (sb_q.size() != 0) begin
         exp    = sb_q.pop_front();
         checks = checks + 1;
         if (outs !== exp) begin
            failures = failures + 1;
            $display("FAIL outputs cyc=%0d got=%b exp=%b", cyc, outs, exp);
         end
      end
      checks = checks + 1;
      if ($countones(outs[7:4]) > 1) begin
         failures = failures + 1;
         $display("FAIL mode_exclusive cyc=%0d got=%b exp=at most one set", cyc, outs[7:4]);
      end
      if (push_arriba)    arr_log.push_back(cyc);
      if (push_abajo)     abj_log.push_back(cyc);
      if (push_izquierda) izq_log.push_back(cyc);
      if (push_derecha)   der_log.push_back(cyc);
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string name, input int got, input int exp);
      checks = checks + 1;
      if (got != exp) begin
         failures = failures + 1;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   initial begin
      int c0;
      int ch;
      int exp_arr [6];
      pins  = '0;
      rst_n = 1'b0;
      tick(3);
      chk("reset_outs", int'(outs), 0);
      rst_n = 1'b1;
      tick(4);

      // Left button: clean press, one pulse at edge 7, nothing on release
      izq_log.delete();
      c0 = cyc;
      pins[2] = 1'b1;
      tick(10);
      pins[2] = 1'b0;
      tick(15);
      chk("izq_count", izq_log.size(), 1);
      if (izq_log.size() > 0) chk("izq_edge", izq_log[0] - c0, 7);

      // Right button bouncing, then settling high
      der_log.delete();
      c0 = cyc;
      for (int k = 0; k < 12; k++) begin
         pins[3] = ((k / 2) % 2 == 0);
         tick(1);
      end
      pins[3] = 1'b1;
      tick(15);
      pins[3] = 1'b0;
      tick(12);
      chk("der_count", der_log.size(), 1);
      if (der_log.size() > 0) chk("der_edge", der_log[0] - c0, 19);

      // Up button held: press then auto-repeat
      arr_log.delete();
      c0 = cyc;
      exp_arr = '{7, 27, 35, 43, 51, 59};
      pins[0] = 1'b1;
      tick(60);
      pins[0] = 1'b0;
      tick(15);
      chk("arr_count", arr_log.size(), 6);
      for (int k = 0; k < 6; k++)
         if (k < arr_log.size()) chk("arr_edge", arr_log[k] - c0, exp_arr[k]);

      // Up and down together: no pulses at all
      arr_log.delete();
      abj_log.delete();
      pins[1:0] = 2'b11;
      tick(40);
      pins[1:0] = 2'b00;
      tick(12);
      chk("both_ud_pulses", arr_log.size() + abj_log.size(), 0);

      // Write mode wins, timer-program ignored until write drops
      c0 = cyc;
      pins[4] = 1'b1;
      tick(3);
      pins[5] = 1'b1;
      tick(3);
      chk("escribe_before", int'(escribe1), 0);
      tick(1);
      chk("escribe_edge7", int'(escribe1), 1);
      tick(10);
      chk("crono_ignored", int'(crono1), 0);
      pins[4] = 1'b0;
      tick(7);
      chk("escribe_drop", int'(escribe1), 0);
      chk("libre_gap", int'(crono1), 0);
      tick(1);
      chk("crono_enter", int'(crono1), 1);
      pins[5] = 1'b0;
      tick(10);

      // Reinit switch blocked while timer-run is active
      pins[6] = 1'b1;
      tick(10);
      chk("cr_activo_on", int'(cr_activo1), 1);
      pins[7] = 1'b1;
      tick(12);
      chk("reset1_blocked", int'(reset1), 0);
      pins[6] = 1'b0;
      tick(7);
      chk("cr_activo_off", int'(cr_activo1), 0);
      chk("reset1_not_yet", int'(reset1), 0);
      tick(1);
      chk("reset1_on", int'(reset1), 1);
      pins[7] = 1'b0;
      tick(10);
      chk("reset1_off", int'(reset1), 0);

      // Async reset in the middle of auto-repeat, then release with the button held
      c0 = cyc;
      pins[0] = 1'b1;
      tick(35);
      chk("arr_before_reset", int'(push_arriba), 1);
      #2 rst_n = 1'b0;
      #1 chk("reset_immediate", int'(outs), 0);
      tick(3);
      rst_n = 1'b1;
      arr_log.delete();
      c0 = cyc;
      tick(12);
      pins[0] = 1'b0;
      tick(12);
      chk("rst_release_count", arr_log.size(), 1);
      if (arr_log.size() > 0) chk("rst_release_edge", arr_log[0] - c0, 7);

      // Random traffic on all channels, checked by the scoreboard
      for (int it = 0; it < 150; it++) begin
         ch = $urandom_range(0, 7);
         pins[ch] = ~pins[ch];
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 4)) begin
               tick(1);
               pins[ch] = ~pins[ch];
               tick(1);
               pins[ch] = ~pins[ch];
            end
         end
         tick($urandom_range(1, 30));
         if (it == 75) begin
            #2 rst_n = 1'b0;
            tick(3);
            rst_n = 1'b1;
         end
      end
      pins = '0;
      tick(20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
